// File: rtl/stage_accumulator.sv
// Cascade stage accumulator: fetches each stage threshold, sums the signed votes
// with saturation, and reports detect/reject per scan window with early exit.
module stage_accumulator #(
  parameter int W_DATA   = 11,
  parameter int W_ACC    = 16,
  parameter int W_ADDR   = 5,
  parameter int N_STAGES = 25
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vote_valid,
  output logic                     vote_ready,
  input  logic signed [W_DATA-1:0] vote_data,
  input  logic                     vote_last,
  output logic                     thr_addr_valid,
  input  logic                     thr_addr_ready,
  output logic        [W_ADDR-1:0] thr_addr_data,
  input  logic                     thr_valid,
  output logic                     thr_ready,
  input  logic signed [W_DATA-1:0] thr_data,
  output logic        [W_ADDR-1:0] cur_stage,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     res_detect,
  output logic        [W_ADDR-1:0] res_stage
);

  localparam logic [2:0] S_FETCH    = 3'd0;
  localparam logic [2:0] S_WAIT_THR = 3'd1;
  localparam logic [2:0] S_ACCUM    = 3'd2;
  localparam logic [2:0] S_COMPARE  = 3'd3;
  localparam logic [2:0] S_RESULT   = 3'd4;

  localparam logic [W_ADDR-1:0] LAST_STAGE = W_ADDR'(N_STAGES - 1);
  localparam logic signed [W_ACC-1:0] ACC_MAX = {1'b0, {(W_ACC-1){1'b1}}};
  localparam logic signed [W_ACC-1:0] ACC_MIN = {1'b1, {(W_ACC-1){1'b0}}};

  logic        [2:0]        state_q, state_d;
  logic        [W_ADDR-1:0] stage_q, stage_d;
  logic signed [W_ACC-1:0]  acc_q, acc_d;
  logic signed [W_DATA-1:0] thr_q, thr_d;
  logic                     res_detect_q, res_detect_d;
  logic        [W_ADDR-1:0] res_stage_q, res_stage_d;

  logic signed [W_ACC:0]   sum;
  logic signed [W_ACC-1:0] acc_sat;
  logic signed [W_ACC-1:0] thr_ext;
  logic                    pass;

  // One guard bit exposes overflow; the two top bits disagree only when it happened.
  assign sum = (W_ACC+1)'(acc_q) + (W_ACC+1)'(vote_data);

  always_comb begin
    case ({sum[W_ACC], sum[W_ACC-1]})
      2'b01:   acc_sat = ACC_MAX;
      2'b10:   acc_sat = ACC_MIN;
      default: acc_sat = sum[W_ACC-1:0];
    endcase
  end

  assign thr_ext = W_ACC'(thr_q);
  assign pass    = (acc_q >= thr_ext);

  // Handshake outputs are forced low while reset is held.
  assign thr_addr_valid = rst && (state_q == S_FETCH);
  assign thr_ready      = rst && (state_q == S_WAIT_THR);
  assign vote_ready     = rst && (state_q == S_ACCUM);
  assign res_valid      = rst && (state_q == S_RESULT);
  assign thr_addr_data  = stage_q;
  assign cur_stage      = stage_q;
  assign res_detect     = res_detect_q;
  assign res_stage      = res_stage_q;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    stage_d      = stage_q;
    acc_d        = acc_q;
    thr_d        = thr_q;
    res_detect_d = res_detect_q;
    res_stage_d  = res_stage_q;
    case (state_q)
      S_FETCH: begin
        if (thr_addr_ready) state_d = S_WAIT_THR;
      end
      S_WAIT_THR: begin
        if (thr_valid) begin
          thr_d   = thr_data;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (vote_valid) begin
          acc_d = acc_sat;
          if (vote_last) state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (!pass) begin
          res_detect_d = 1'b0;
          res_stage_d  = stage_q;
          state_d      = S_RESULT;
        end else if (stage_q == LAST_STAGE) begin
          res_detect_d = 1'b1;
          res_stage_d  = stage_q;
          state_d      = S_RESULT;
        end else begin
          stage_d = stage_q + W_ADDR'(1);
          acc_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          stage_d = '0;
          acc_d   = '0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q      <= S_FETCH;
      stage_q      <= '0;
      acc_q        <= '0;
      thr_q        <= '0;
      res_detect_q <= 1'b0;
      res_stage_q  <= '0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      acc_q        <= acc_d;
      thr_q        <= thr_d;
      res_detect_q <= res_detect_d;
      res_stage_q  <= res_stage_d;
    end
  end

endmodule

// File: tb/tb_stage_accumulator.sv
// Bench for stage_accumulator: instance A uses the defaults (25 stages, 16-bit acc),
// instance B uses 1 stage with a 12-bit acc; sel routes the shared stimulus to one of them.
module tb_stage_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b0;
  logic               sel = 1'b0;
  logic               stall_en = 1'b0;
  logic               vote_valid = 1'b0, vote_last = 1'b0;
  logic signed [10:0] vote_data = '0;
  logic               thr_addr_ready = 1'b0, thr_valid = 1'b0, res_ready = 1'b0;
  logic signed [10:0] thr_data = '0;

  logic       vote_ready, thr_addr_valid, thr_ready, res_valid, res_detect;
  logic [4:0] thr_addr_data, cur_stage, res_stage;

  logic       a_vote_ready, a_thr_addr_valid, a_thr_ready, a_res_valid, a_res_detect;
  logic [4:0] a_thr_addr_data, a_cur_stage, a_res_stage;
  logic       b_vote_ready, b_thr_addr_valid, b_thr_ready, b_res_valid, b_res_detect;
  logic [4:0] b_thr_addr_data, b_cur_stage, b_res_stage;

  stage_accumulator u_dut_a (
    .clk(clk), .rst(rst),
    .vote_valid(vote_valid & ~sel), .vote_ready(a_vote_ready),
    .vote_data(vote_data), .vote_last(vote_last),
    .thr_addr_valid(a_thr_addr_valid), .thr_addr_ready(thr_addr_ready & ~sel),
    .thr_addr_data(a_thr_addr_data),
    .thr_valid(thr_valid & ~sel), .thr_ready(a_thr_ready), .thr_data(thr_data),
    .cur_stage(a_cur_stage),
    .res_valid(a_res_valid), .res_ready(res_ready & ~sel),
    .res_detect(a_res_detect), .res_stage(a_res_stage)
  );

  stage_accumulator #(.W_ACC(12), .N_STAGES(1)) u_dut_b (
    .clk(clk), .rst(rst),
    .vote_valid(vote_valid & sel), .vote_ready(b_vote_ready),
    .vote_data(vote_data), .vote_last(vote_last),
    .thr_addr_valid(b_thr_addr_valid), .thr_addr_ready(thr_addr_ready & sel),
    .thr_addr_data(b_thr_addr_data),
    .thr_valid(thr_valid & sel), .thr_ready(b_thr_ready), .thr_data(thr_data),
    .cur_stage(b_cur_stage),
    .res_valid(b_res_valid), .res_ready(res_ready & sel),
    .res_detect(b_res_detect), .res_stage(b_res_stage)
  );

  assign vote_ready     = sel ? b_vote_ready     : a_vote_ready;
  assign thr_addr_valid = sel ? b_thr_addr_valid : a_thr_addr_valid;
  assign thr_addr_data  = sel ? b_thr_addr_data  : a_thr_addr_data;
  assign thr_ready      = sel ? b_thr_ready      : a_thr_ready;
  assign cur_stage      = sel ? b_cur_stage      : a_cur_stage;
  assign res_valid      = sel ? b_res_valid      : a_res_valid;
  assign res_detect     = sel ? b_res_detect     : a_res_detect;
  assign res_stage      = sel ? b_res_stage      : a_res_stage;

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Threshold ROM model with an optional random-stall responder.
  logic signed [10:0] thr_table [32];
  logic               thr_pend = 1'b0;
  logic [4:0]         thr_pend_addr = '0;
  logic [4:0]         addr_log [$];

  always @(posedge clk) begin
    if (!rst) thr_pend <= 1'b0;
    else if (thr_addr_valid && thr_addr_ready) begin
      thr_pend      <= 1'b1;
      thr_pend_addr <= thr_addr_data;
      addr_log.push_back(thr_addr_data);
    end else if (thr_valid && thr_ready) thr_pend <= 1'b0;
  end

  always @(negedge clk) begin
    thr_addr_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (!rst || !thr_pend) thr_valid = 1'b0;
    else if (!thr_valid)   thr_valid = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    thr_data = thr_table[thr_pend_addr];
  end

  task automatic do_reset();
    rst = 1'b0;
    vote_valid = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_handshakes", {vote_ready, thr_addr_valid, thr_ready, res_valid}, 0);
    check("rst_res_detect", res_detect, 0);
    check("rst_res_stage", res_stage, 0);
    check("rst_cur_stage", cur_stage, 0);
    rst = 1'b1;
    #1;
    check("rst_release_fetch", {thr_addr_valid, thr_addr_data}, {1'b1, 5'd0});
  endtask

  task automatic send_vote(input logic signed [10:0] d, input bit last);
    int n = 0;
    if (stall_en) repeat ($urandom_range(0, 2)) @(negedge clk);
    vote_valid = 1'b1;
    vote_data  = d;
    vote_last  = last;
    do begin
      @(posedge clk);
      n++;
    end while (!vote_ready && n < 500);
    if (n >= 500) check("vote_accept_timeout", 0, 1);
    @(negedge clk);
    vote_valid = 1'b0;
    vote_last  = 1'b0;
  endtask

  task automatic wait_result(input string name, input bit det, input logic [4:0] stg);
    int n = 0;
    while (!res_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) begin
      check({name, "_res_timeout"}, 0, 1);
      return;
    end
    check({name, "_detect"}, res_detect, det);
    check({name, "_stage"}, res_stage, stg);
    if (stall_en) repeat ($urandom_range(1, 3)) begin
      @(negedge clk);
      check({name, "_hold"}, {res_valid, res_detect, res_stage}, {1'b1, det, stg});
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check({name, "_after_xfer"}, {res_valid, cur_stage}, 0);
  endtask

  task automatic check_addrs(input string name, input int n);
    int bad = 0;
    check({name, "_n_addr"}, addr_log.size(), n);
    foreach (addr_log[i]) if (addr_log[i] != 5'(i)) bad++;
    check({name, "_addr_order"}, bad, 0);
  endtask

  typedef struct {
    string      name;
    bit         sel;
    int         thr[4];
    int         nv;
    int         votes[8];
    bit [7:0]   last_mask;
    bit         exp_det;
    logic [4:0] exp_stage;
    int         exp_addrs;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v, input bit stall);
    if (v.sel != sel) begin
      sel = v.sel;
      do_reset();
    end
    stall_en = stall;
    foreach (thr_table[i]) thr_table[i] = '0;
    for (int i = 0; i < 4; i++) thr_table[i] = 11'(v.thr[i]);
    addr_log.delete();
    for (int j = 0; j < v.nv; j++) send_vote(11'(v.votes[j]), v.last_mask[j]);
    wait_result(v.name, v.exp_det, v.exp_stage);
    check_addrs(v.name, v.exp_addrs);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{name:"fail_s2", sel:1'b0, thr:'{0, 0, 10, 0}, nv:5,
                votes:'{1, 2, 4, -1, 6, 0, 0, 0}, last_mask:8'b0001_0011,
                exp_det:1'b0, exp_stage:5'd2, exp_addrs:3};
    vecs[1] = '{name:"fail_s0_neg", sel:1'b0, thr:'{-5, 0, 0, 0}, nv:2,
                votes:'{-3, -3, 0, 0, 0, 0, 0, 0}, last_mask:8'b0000_0010,
                exp_det:1'b0, exp_stage:5'd0, exp_addrs:1};
    vecs[2] = '{name:"eq_boundary", sel:1'b0, thr:'{3, -2, 7, 0}, nv:3,
                votes:'{3, -2, 6, 0, 0, 0, 0, 0}, last_mask:8'b0000_0111,
                exp_det:1'b0, exp_stage:5'd2, exp_addrs:3};
    vecs[3] = '{name:"acc_clear", sel:1'b0, thr:'{5, 5, 0, 0}, nv:2,
                votes:'{5, 4, 0, 0, 0, 0, 0, 0}, last_mask:8'b0000_0011,
                exp_det:1'b0, exp_stage:5'd1, exp_addrs:2};
    vecs[4] = '{name:"single_pass", sel:1'b1, thr:'{5, 0, 0, 0}, nv:2,
                votes:'{3, 2, 0, 0, 0, 0, 0, 0}, last_mask:8'b0000_0010,
                exp_det:1'b1, exp_stage:5'd0, exp_addrs:1};
    vecs[5] = '{name:"single_fail", sel:1'b1, thr:'{5, 0, 0, 0}, nv:2,
                votes:'{3, 1, 0, 0, 0, 0, 0, 0}, last_mask:8'b0000_0010,
                exp_det:1'b0, exp_stage:5'd0, exp_addrs:1};
    vecs[6] = '{name:"sat_pos", sel:1'b1, thr:'{1023, 0, 0, 0}, nv:5,
                votes:'{1023, 1023, 1023, 1023, -1024, 0, 0, 0}, last_mask:8'b0001_0000,
                exp_det:1'b1, exp_stage:5'd0, exp_addrs:1};
    vecs[7] = '{name:"sat_neg", sel:1'b1, thr:'{-1024, 0, 0, 0}, nv:5,
                votes:'{-1024, -1024, -1024, -1024, 1023, 0, 0, 0}, last_mask:8'b0001_0000,
                exp_det:1'b0, exp_stage:5'd0, exp_addrs:1};

    foreach (thr_table[i]) thr_table[i] = '0;
    do_reset();

    // Clean run first, then the same vectors under random stalls.
    for (int pass = 0; pass < 2; pass++)
      foreach (vecs[i]) run_vec(vecs[i], pass[0]);

    // Result valid two cycles after the last vote.
    stall_en = 1'b0;
    thr_table[0] = 11'sd5;
    addr_log.delete();
    send_vote(11'sd3, 1'b0);
    send_vote(11'sd2, 1'b1);
    check("lat_compare_cycle", res_valid, 0);
    @(negedge clk);
    check("lat_result_cycle", res_valid, 1);
    wait_result("latency", 1'b1, 5'd0);

    // Full 25-stage detect on instance A.
    sel = 1'b0;
    do_reset();
    foreach (thr_table[i]) thr_table[i] = '0;
    addr_log.delete();
    for (int s = 0; s < 25; s++) send_vote(11'sd1, 1'b1);
    wait_result("full_detect", 1'b1, 5'd24);
    check_addrs("full_detect", 25);

    // Reset in the middle of stage 3 with a large partial sum.
    addr_log.delete();
    for (int s = 0; s < 3; s++) send_vote(11'sd1, 1'b1);
    send_vote(11'sd100, 1'b0);
    check("mid_cur_stage", cur_stage, 3);
    rst = 1'b0;
    thr_table[0] = 11'sd1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_fetch", {thr_addr_valid, thr_addr_data}, {1'b1, 5'd0});
    check("mid_rst_stage_res", {cur_stage, res_valid}, 0);
    send_vote(11'sd0, 1'b1);
    wait_result("mid_rst_acc_cleared", 1'b0, 5'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/stage_accumulator.md
Name: stage_accumulator

Overview:
- Consumer paired with stageThreshold, placed downstream of the weak-classifier evaluator.
- Accumulates signed weak-classifier votes for the current cascade stage and fetches that stage's threshold over the stageThreshold address/data handshakes.
- Decides pass/fail per stage and emits one detect/reject result per scan window, with early exit on the first failing stage.

Parameters:
- W_DATA, 11, width of signed vote and stage threshold.
- W_ACC, 16, width of signed stage accumulator (W_ACC >= W_DATA).
- W_ADDR, 5, stage index / threshold ROM address width.
- N_STAGES, 25, number of cascade stages (N_STAGES <= 2**W_ADDR).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- vote_valid  in  1  vote available.
- vote_ready  out  1  vote accepted when valid&ready.
- vote_data  in  W_DATA  signed weak-classifier vote.
- vote_last  in  1  vote is the final one of the current stage.
- thr_addr_valid  out  1  threshold address request.
- thr_addr_ready  in  1  stageThreshold accepts address.
- thr_addr_data  out  W_ADDR  stage index to fetch.
- thr_valid  in  1  threshold data valid.
- thr_ready  out  1  threshold data accepted.
- thr_data  in  W_DATA  signed stage threshold.
- cur_stage  out  W_ADDR  stage currently being evaluated; upstream uses it to sequence classifiers.
- res_valid  out  1  window result valid.
- res_ready  in  1  result consumer ready.
- res_detect  out  1  1 = all stages passed, 0 = rejected.
- res_stage  out  W_ADDR  failing stage index, or N_STAGES-1 on detect.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=FETCH, stage=0, acc=0, thr_reg=0.
  - All valid/ready outputs 0.
  - res_detect=0, res_stage=0, cur_stage=0.
- Handshakes: a transfer occurs on a cycle with valid&ready high. Once valid is asserted, it holds with stable data until the transfer completes.
- FSM states:
  - FETCH: thr_addr_valid=1, thr_addr_data=stage. Go to WAIT_THR on address transfer.
  - WAIT_THR: thr_ready=1. On thr transfer, thr_reg<=thr_data, then go to ACCUM.
  - ACCUM: vote_ready=1. Each vote transfer does acc<=sat(acc+sext(vote_data)). If vote_last is set on that transfer, go to COMPARE.
  - COMPARE (1 cycle, no handshakes): pass = (acc >= sext(thr_reg)), signed compare.
    - pass and stage<N_STAGES-1: stage<=stage+1, acc<=0, go to FETCH.
    - pass and stage==N_STAGES-1: res_detect<=1, res_stage<=stage, go to RESULT.
    - fail: res_detect<=0, res_stage<=stage, go to RESULT.
  - RESULT: res_valid=1. On res transfer: stage<=0, acc<=0, go to FETCH.
- vote_ready is 0 in every state except ACCUM. Votes arriving in FETCH/WAIT_THR/COMPARE/RESULT stall upstream and are never dropped.
- Saturation: acc clamps at +(2**(W_ACC-1)-1) and -(2**(W_ACC-1)); it never wraps.
- Latency:
  - Last vote accepted at cycle T → COMPARE at T+1 → res_valid or thr_addr_valid asserted at T+2.
  - Best-case stage turnaround is 3 cycles of overhead plus the stageThreshold read latency.
- The vote carrying vote_last is included in acc before the compare.
- A stage with a single vote (vote_last on its first vote) is legal.
- cur_stage = stage register. It changes only in COMPARE (increment) or on the RESULT transfer (to 0).
- Early exit: on fail, the remaining stages of the window are skipped. Upstream restarts the next window when cur_stage returns to 0 after the res transfer.
- Backpressure: res_ready held low keeps the FSM in RESULT indefinitely with outputs stable. Stalls on thr_addr_ready or thr_valid likewise hold state.
- Reset mid-operation: an accumulation or pending result is discarded and the FSM returns to FETCH stage 0 next cycle.

Test Plan:
- Single-stage pass (N_STAGES=1): threshold=5, votes +3,+2(last) → acc=5 ≥ 5, res_detect=1, res_stage=0, res_valid 2 cycles after the last vote.
- Fail at stage 2 (N_STAGES=4): stages 0,1 pass; stage 2 threshold=10, votes +4,-1,+6(last) → acc=9, res_detect=0, res_stage=2; no address 3 requested; cur_stage=0 after res transfer.
- Full detect (N_STAGES=25, all thresholds=0, single vote +1 per stage) → exactly 25 address requests 0..24 in order; res_detect=1, res_stage=24.
- Saturation (W_ACC=12): 4 votes of +1023 → acc clamps at 2047; 4 votes of -1024 → acc clamps at -2048; threshold=-1024 → pass/fail per clamped value.
- Backpressure: random toggling of thr_addr_ready, thr_valid, vote_valid and res_ready → every vote counted once, results identical to the no-stall run, res outputs stable while res_ready=0.
- Reset mid-window: assert rst=0 during ACCUM of stage 3 → next cycle thr_addr_valid=1 with thr_addr_data=0, acc=0, no res_valid.
